control_pipe: RTL

- Pipelined control path for the processor. Instantiates the existing combinational Control decoder on the ID-stage OpCode/Function.
- Stages the decoded bundle through EX, a configurable number of MEM stages, and WB, with valid bits, stall, flush and bubble insertion.
- Adds a multi-cycle FPU occupancy counter that freezes ID/EX for long-latency FP multiply/divide.
- Sits between the IF/ID register and the datapath stage muxes.

---
 rtl/control_pipe.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_pipe.sv
// Pipelined control path: decodes the ID-stage instruction and carries the
// control bundle through EX, MEM_STAGES memory stages and WB. The pipeline
// has valid bits, stall/flush/bubble handling and an FPU occupancy counter
// that holds EX while a long-latency FP multiply/divide is executing.

package control_pipe_pkg;
  // Fields used only in ID: branch/jump steering
  typedef struct packed {
    logic [1:0] jump_type;
    logic       cond_src;
    logic       branch_cond;
    logic       fp_src;
  } id_ctrl_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_cruft;
    logic [2:0] fpu_op;
    logic       alu_src;
    logic       ext_imm;
  } ex_ctrl_t;

  typedef struct packed {
    logic [1:0] mem_size;
    logic       mem_we;
    logic       ext_mem;
  } mem_ctrl_t;

  typedef struct packed {
    logic [1:0] din_src;
    logic       reg_we;
    logic       fp_dest;
    logic       reg_dest;
  } wb_ctrl_t;

  typedef struct packed {
    id_ctrl_t  id;
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;
endpackage

// Combinational instruction decoder (DLX-style encodings)
module control_decoder
  import control_pipe_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output ctrl_t      ctrl
);
  // Decode opcode/function into the full control bundle
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    ctrl = '0;
    case (op)
      6'h00: begin  // R-type integer ALU; alu_cruft[0]=unsigned, [1]=arithmetic shift
        ctrl.wb.reg_we   = 1'b1;
        ctrl.wb.reg_dest = 1'b1;
        case (fn)
          6'h20: ctrl.ex.alu_op = 3'd0;
          6'h21: begin ctrl.ex.alu_op = 3'd0; ctrl.ex.alu_cruft = 2'b01; end
          6'h22: ctrl.ex.alu_op = 3'd1;
          6'h23: begin ctrl.ex.alu_op = 3'd1; ctrl.ex.alu_cruft = 2'b01; end
          6'h24: ctrl.ex.alu_op = 3'd2;
          6'h25: ctrl.ex.alu_op = 3'd3;
          6'h26: ctrl.ex.alu_op = 3'd4;
          6'h04: ctrl.ex.alu_op = 3'd5;
          6'h06: ctrl.ex.alu_op = 3'd6;
          6'h07: begin ctrl.ex.alu_op = 3'd6; ctrl.ex.alu_cruft = 2'b10; end
          6'h2A: ctrl.ex.alu_op = 3'd7;
          default: begin ctrl.wb.reg_we = 1'b0; ctrl.wb.reg_dest = 1'b0; end
        endcase
      end
      6'h01: begin  // FP-type: ADDF/SUBF/MULTF/DIVF map to FPUOp 0..3
        if (fn[5:2] == 4'h0) begin
          ctrl.id.fp_src   = 1'b1;
          ctrl.ex.fpu_op   = {1'b0, fn[1:0]};
          ctrl.wb.din_src  = 2'b10;
          ctrl.wb.reg_we   = 1'b1;
          ctrl.wb.fp_dest  = 1'b1;
          ctrl.wb.reg_dest = 1'b1;
        end
      end
      6'h02: ctrl.id.jump_type = 2'b10;                       // J
      6'h03: begin                                            // JAL
        ctrl.id.jump_type = 2'b10;
        ctrl.wb.din_src   = 2'b11;
        ctrl.wb.reg_we    = 1'b1;
      end
      6'h04, 6'h05: begin                                     // BEQZ / BNEZ
        ctrl.id.jump_type   = 2'b01;
        ctrl.id.branch_cond = op[0];
      end
      6'h06, 6'h07: begin                                     // BFPT / BFPF
        ctrl.id.jump_type   = 2'b01;
        ctrl.id.cond_src    = 1'b1;
        ctrl.id.branch_cond = ~op[0];
      end
      6'h08: begin                                            // ADDI
        ctrl.ex.alu_src = 1'b1;
        ctrl.ex.ext_imm = 1'b1;
        ctrl.wb.reg_we  = 1'b1;
      end
      6'h0C: begin                                            // ANDI (zero-extended)
        ctrl.ex.alu_src = 1'b1;
        ctrl.ex.alu_op  = 3'd2;
        ctrl.wb.reg_we  = 1'b1;
      end
      6'h23: begin                                            // LW
        ctrl.ex.alu_src   = 1'b1;
        ctrl.ex.ext_imm   = 1'b1;
        ctrl.mem.mem_size = 2'b11;
        ctrl.mem.ext_mem  = 1'b1;
        ctrl.wb.din_src   = 2'b01;
        ctrl.wb.reg_we    = 1'b1;
      end
      6'h2B: begin                                            // SW
        ctrl.ex.alu_src   = 1'b1;
        ctrl.ex.ext_imm   = 1'b1;
        ctrl.mem.mem_size = 2'b11;
        ctrl.mem.mem_we   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int         MUL_LAT    = 4,
  parameter int         DIV_LAT    = 8,
  parameter logic [2:0] MUL_CODE   = 3'b010,
  parameter logic [2:0] DIV_CODE   = 3'b011,
  parameter int         MEM_STAGES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:5] OpCode,
  input  logic [0:5] Function,
  input  logic       InstValid,
  input  logic       Stall,
  input  logic       Flush,
  output logic       IDAccept,
  output logic [0:1] ID_JumpType,
  output logic       ID_CondSrc,
  output logic       ID_BranchCond,
  output logic       ID_FPSrc,
  output logic [0:2] EX_ALUOp,
  output logic [0:1] EX_ALUCruft,
  output logic [0:2] EX_FPUOp,
  output logic       EX_ALUSrc,
  output logic       EX_ExtImm,
  output logic [0:1] MEM_MEMSize,
  output logic       MEM_MEMWE,
  output logic       MEM_ExtMEM,
  output logic [0:1] WB_DInSrc,
  output logic       WB_RegWE,
  output logic       WB_FPDest,
  output logic       WB_RegDest,
  output logic       EX_Valid,
  output logic       MEM_Valid,
  output logic       WB_Valid,
  output logic       Busy
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  // Stages after MEM1 only need the WB fields
  typedef struct packed {
    logic     valid;
    wb_ctrl_t wb;
  } tail_t;

  ctrl_t                  dec;
  logic                   busy;
  logic                   ex_load;
  logic                   ex_valid_q, ex_valid_d;
  ex_ctrl_t               ex_q,       ex_d;
  mem_ctrl_t              ex_mem_q,   ex_mem_d;
  wb_ctrl_t               ex_wb_q,    ex_wb_d;
  mem_ctrl_t              mem1_q,     mem1_d;
  tail_t [MEM_STAGES-1:0] tail_q,     tail_d;
  tail_t                  wb_q,       wb_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;

  control_decoder u_dec (
    .op   (OpCode),
    .fn   (Function),
    .ctrl (dec)
  );

  assign busy    = (cnt_q != '0);
  assign ex_load = ~busy & InstValid & ~Stall & ~Flush;

  // EX stage: hold while busy, else load the decoded bundle or a bubble; arm the FPU counter
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    ex_mem_d   = ex_mem_q;
    ex_wb_d    = ex_wb_q;
    cnt_d      = cnt_q;
    if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (ex_load) begin
      ex_valid_d = 1'b1;
      ex_d       = dec.ex;
      ex_mem_d   = dec.mem;
      ex_wb_d    = dec.wb;
      if (dec.ex.fpu_op == MUL_CODE)      cnt_d = CNT_W'(MUL_LAT - 1);
      else if (dec.ex.fpu_op == DIV_CODE) cnt_d = CNT_W'(DIV_LAT - 1);
      else                                cnt_d = '0;
    end else begin
      ex_valid_d = 1'b0;
      ex_d       = '0;
      ex_mem_d   = '0;
      ex_wb_d    = '0;
      cnt_d      = '0;
    end
  end

  // Downstream shift: MEM1 takes EX (bubble while busy), later stages always advance
  always_comb begin
    tail_d          = '0;
    mem1_d          = busy ? '0 : ex_mem_q;
    tail_d[0].valid = ~busy & ex_valid_q;
    tail_d[0].wb    = busy ? '0 : ex_wb_q;
    for (int k = 1; k < MEM_STAGES; k++) begin
      tail_d[k] = tail_q[k-1];
    end
    wb_d = tail_q[MEM_STAGES-1];
  end

  // Pipeline and counter registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      ex_mem_q   <= '0;
      ex_wb_q    <= '0;
      mem1_q     <= '0;
      tail_q     <= '0;
      wb_q       <= '0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      ex_mem_q   <= ex_mem_d;
      ex_wb_q    <= ex_wb_d;
      mem1_q     <= mem1_d;
      tail_q     <= tail_d;
      wb_q       <= wb_d;
      cnt_q      <= cnt_d;
    end
  end

  assign IDAccept      = ~busy & ~Stall;
  assign ID_JumpType   = InstValid ? dec.id.jump_type : 2'b00;
  assign ID_CondSrc    = InstValid & dec.id.cond_src;
  assign ID_BranchCond = InstValid & dec.id.branch_cond;
  assign ID_FPSrc      = InstValid & dec.id.fp_src;

  assign EX_ALUOp    = ex_q.alu_op;
  assign EX_ALUCruft = ex_q.alu_cruft;
  assign EX_FPUOp    = ex_q.fpu_op;
  assign EX_ALUSrc   = ex_q.alu_src;
  assign EX_ExtImm   = ex_q.ext_imm;
  assign EX_Valid    = ex_valid_q;

  assign MEM_MEMSize = mem1_q.mem_size;
  assign MEM_MEMWE   = mem1_q.mem_we & tail_q[0].valid;
  assign MEM_ExtMEM  = mem1_q.ext_mem;
  assign MEM_Valid   = tail_q[0].valid;

  assign WB_DInSrc  = wb_q.wb.din_src;
  assign WB_RegWE   = wb_q.wb.reg_we & wb_q.valid;
  assign WB_FPDest  = wb_q.wb.fp_dest;
  assign WB_RegDest = wb_q.wb.reg_dest;
  assign WB_Valid   = wb_q.valid;

  assign Busy = busy;
endmodule
